// File: rtl/cordic_tan_seq.sv
// Iterative linear-mode CORDIC divider: one add/sub stage reused ITER times
// to drive y toward zero, accumulating z ~= EI * y / x.
module cordic_tan_seq #(
    parameter int unsigned       WIDTH = 17,
    parameter int unsigned       ITER  = 16,
    parameter logic [WIDTH-1:0]  EI    = WIDTH'(16384)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z_out,
    output logic [WIDTH-1:0] y_res,
    output logic             div_zero,
    output logic             busy
);

    localparam int unsigned KW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic signed [WIDTH-1:0] EI_S = $signed(EI);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic signed [WIDTH-1:0]  x_q, x_d;
    logic signed [WIDTH-1:0]  y_q, y_d;
    logic signed [WIDTH-1:0]  z_q, z_d;
    logic        [KW-1:0]     k_q, k_d;
    logic                     div_zero_q, div_zero_d;
    logic                     out_valid_q, out_valid_d;

    logic                     last_iter;
    logic                     dir_pos;
    logic signed [WIDTH-1:0]  x_sh;
    logic signed [WIDTH-1:0]  e_sh;

    assign last_iter = (k_q == KW'(ITER - 1));
    // Same sign of y and x (y==0 counts as positive) means subtract to move y toward zero.
    assign dir_pos   = ~(y_q[WIDTH-1] ^ x_q[WIDTH-1]);
    assign x_sh      = x_q >>> k_q;
    assign e_sh      = EI_S >>> k_q;

    // State register and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            k_q         <= '0;
            div_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            k_q         <= k_d;
            div_zero_q  <= div_zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic; abort wins over both iteration and out_ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (x_in == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        k_d         = k_q;
        div_zero_d  = div_zero_q;
        out_valid_d = (state_d == DONE);
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d        = $signed(x_in);
                    y_d        = $signed(y_in);
                    z_d        = '0;
                    k_d        = '0;
                    div_zero_d = (x_in == '0);
                end
            end
            RUN: begin
                if (!abort) begin
                    if (dir_pos) begin
                        y_d = y_q - x_sh;
                        z_d = z_q + e_sh;
                    end else begin
                        y_d = y_q + x_sh;
                        z_d = z_q - e_sh;
                    end
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    div_zero_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign z_out     = z_q;
    assign y_res     = y_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_cordic_tan_seq.sv
// Directed bench for cordic_tan_seq: hand-computed quotients, latency,
// divide-by-zero, backpressure, abort and mid-run reset.
module tb_cordic_tan_seq;

    localparam int unsigned W = 17;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x_in;
    logic [W-1:0] y_in;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z_out;
    logic [W-1:0] y_res;
    logic         div_zero;
    logic         busy;

    int total = 0;
    int bad   = 0;

    cordic_tan_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_out     (z_out),
        .y_res     (y_res),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference iteration equations, used for the extra model vectors
    function automatic void model(input int x, input int y, output int zr, output int yr);
        logic signed [W-1:0] xs, ys, zs;
        xs = W'(x);
        ys = W'(y);
        zs = '0;
        for (int k = 0; k < 16; k++) begin
            if (ys[W-1] == xs[W-1]) begin
                ys = ys - (xs >>> k);
                zs = zs + (17'sd16384 >>> k);
            end else begin
                ys = ys + (xs >>> k);
                zs = zs - (17'sd16384 >>> k);
            end
        end
        zr = int'(zs);
        yr = int'(ys);
    endfunction

    function automatic int sz(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Present one operand pair in IDLE and return just after the accept edge
    task automatic start_op(input int x, input int y);
        in_valid = 1'b1;
        x_in     = W'(x);
        y_in     = W'(y);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full operation with out_ready held high; checks latency, value and drain
    task automatic do_vec(input string tag, input int x, input int y,
                          input int zexp, input int yexp, input int near);
        int lat;
        int dz;
        out_ready = 1'b1;
        chk({tag, "_rdy"}, int'(in_ready), 1);
        start_op(x, y);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_z"}, sz(z_out), zexp);
        chk({tag, "_y"}, sz(y_res), yexp);
        dz = sz(z_out) - near;
        chk({tag, "_near"}, int'(dz <= 2 && dz >= -2), 1);
        @(posedge clk); #1;
        chk({tag, "_drain"}, int'(in_ready && !out_valid), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int mz, my;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x_in      = '0;
        y_in      = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_z", sz(z_out), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed bit-exact results of the 16 iterations
        do_vec("pp", 16384, 8192, 8193, -1, 8192);
        do_vec("np", -16384, 8192, -8193, 0, -8192);
        do_vec("pn", 16384, -12288, -12287, -1, -12288);
        do_vec("nn", -8192, -4096, 8191, -1, 8192);   // y/x = 0.5

        // Extra vectors against the iteration model, including out-of-domain 3.0
        model(12000, 5000, mz, my);
        do_vec("m1", 12000, 5000, mz, my, 6827);
        model(-7000, 3000, mz, my);
        do_vec("m2", -7000, 3000, mz, my, -7022);
        model(4000, 12000, mz, my);
        do_vec("m3", 4000, 12000, mz, my, mz);

        // Divide by zero
        out_ready = 1'b0;
        start_op(0, 1234);
        chk("dz_valid_c1", int'(out_valid), 1);
        chk("dz_flag", int'(div_zero), 1);
        chk("dz_z", sz(z_out), 0);
        chk("dz_y", sz(y_res), 1234);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("dz_clear", int'(!div_zero && !out_valid && in_ready), 1);

        // Backpressure: result held, new operands ignored
        start_op(16384, 8192);
        wait_done(lat);
        chk("bp_lat", lat, 16);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            x_in     = '0;
            y_in     = W'(777);
            @(posedge clk); #1;
            chk("bp_hold", int'(out_valid && !in_ready && busy && !div_zero &&
                                sz(z_out) == 8193 && sz(y_res) == -1), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release", int'(in_ready && !out_valid), 1);
        start_op(0, -55);
        chk("bp_next_accept", int'(out_valid && div_zero && sz(y_res) == -55), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Abort at k=7 with in_valid held high throughout
        seen     = 0;
        in_valid = 1'b1;
        x_in     = W'(16384);
        y_in     = W'(8192);
        @(posedge clk); #1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("ab_busy", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        if (out_valid) seen = 1;
        chk("ab_idle", int'(in_ready && !busy), 1);
        chk("ab_noval", seen, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ab_reaccept", int'(busy), 1);
        wait_done(lat);
        chk("ab_lat", lat, 16);
        chk("ab_z", sz(z_out), 8193);

        // Abort in DONE beats out_ready and clears the result
        abort     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("ab_done", int'(in_ready && !out_valid), 1);
        start_op(0, 9);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("ab_dz_clear", int'(!div_zero && !out_valid && in_ready), 1);

        // Reset mid-run at k=5
        start_op(16384, 8192);
        repeat (5) @(posedge clk);
        #1;
        chk("mr_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", int'(out_valid), 0);
        chk("mr_busy_rst", int'(busy), 0);
        chk("mr_z", sz(z_out), 0);
        chk("mr_y", sz(y_res), 0);
        chk("mr_dz", int'(div_zero), 0);
        chk("mr_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr_after", int'(in_ready && !busy), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
